// File: rtl/fc_layer_seq.sv
// Fully-connected layer sequencer: serial activation load, multicycle settle window
// for the combinational neurons, single-edge capture of all results, handshaked drain.
module fc_layer_seq #(
  parameter int WIDTH   = 8,
  parameter int IN      = 128,
  parameter int NEURONS = 10,
  parameter int SETTLE  = 4,
  localparam int OW = WIDTH*2 + $clog2(IN),
  localparam int IW = (IN > 1) ? $clog2(IN) : 1,
  localparam int NW = (NEURONS > 1) ? $clog2(NEURONS) : 1,
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic [IN*WIDTH-1:0]   x_bus,
  input  logic [NEURONS*OW-1:0] z_bus,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OW-1:0]         out_data,
  output logic [NW-1:0]         out_idx,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t                        state_r, state_nx_s;
  logic [IW-1:0]                 wr_cnt_r, wr_nx_s;
  logic [NW-1:0]                 rd_cnt_r, rd_nx_s;
  logic [SW-1:0]                 st_cnt_r, st_nx_s;
  logic                          x_we_s;
  logic                          z_cap_s;
  logic [IN-1:0][WIDTH-1:0]      x_buf_r;
  logic [NEURONS-1:0][OW-1:0]    z_reg_r;
  logic [NEURONS-1:0][OW-1:0]    z_nx_s;

  logic                          in_ready_r;
  logic                          out_valid_r;
  logic                          out_last_r;
  logic                          busy_r;
  logic [NW-1:0]                 out_idx_r;
  logic [OW-1:0]                 out_data_r;

  // Next-state, counter and write-enable decode; flush overrides every handshake.
  always_comb begin
    state_nx_s = state_r;
    wr_nx_s    = wr_cnt_r;
    rd_nx_s    = rd_cnt_r;
    st_nx_s    = st_cnt_r;
    x_we_s     = 1'b0;
    z_cap_s    = 1'b0;
    if (flush && (state_r != ST_IDLE)) begin
      state_nx_s = ST_LOAD;
      wr_nx_s    = '0;
      rd_nx_s    = '0;
      st_nx_s    = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_LOAD;
        end
        ST_LOAD: begin
          if (in_valid) begin
            x_we_s = 1'b1;
            if (wr_cnt_r == IW'(IN-1)) begin
              wr_nx_s    = '0;
              state_nx_s = ST_SETTLE;
            end else begin
              wr_nx_s = wr_cnt_r + IW'(1);
            end
          end else begin
            wr_nx_s = wr_cnt_r;
          end
        end
        ST_SETTLE: begin
          if (st_cnt_r == SW'(SETTLE-1)) begin
            st_nx_s    = '0;
            z_cap_s    = 1'b1;
            state_nx_s = ST_DRAIN;
          end else begin
            st_nx_s = st_cnt_r + SW'(1);
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (rd_cnt_r == NW'(NEURONS-1)) begin
              rd_nx_s    = '0;
              state_nx_s = ST_LOAD;
            end else begin
              rd_nx_s = rd_cnt_r + NW'(1);
            end
          end else begin
            rd_nx_s = rd_cnt_r;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // Result bank as it will look after this edge, so the output word can be registered.
  always_comb begin
    if (z_cap_s) begin
      z_nx_s = z_bus;
    end else begin
      z_nx_s = z_reg_r;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      wr_cnt_r <= '0;
      rd_cnt_r <= '0;
      st_cnt_r <= '0;
    end else begin
      state_r  <= state_nx_s;
      wr_cnt_r <= wr_nx_s;
      rd_cnt_r <= rd_nx_s;
      st_cnt_r <= st_nx_s;
    end
  end

  // Activation buffer: written only by accepted LOAD elements, frozen otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_buf_r <= '0;
    end else if (x_we_s) begin
      x_buf_r[wr_cnt_r] <= in_data;
    end
  end

  // Neuron result bank: z_bus is sampled on the final settle edge only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_reg_r <= '0;
    end else begin
      z_reg_r <= z_nx_s;
    end
  end

  // Registered status and output word, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      out_idx_r   <= '0;
      out_data_r  <= '0;
    end else begin
      in_ready_r  <= (state_nx_s == ST_LOAD);
      out_valid_r <= (state_nx_s == ST_DRAIN);
      out_last_r  <= (state_nx_s == ST_DRAIN) && (rd_nx_s == NW'(NEURONS-1));
      busy_r      <= (state_nx_s == ST_SETTLE) || (state_nx_s == ST_DRAIN);
      out_idx_r   <= rd_nx_s;
      out_data_r  <= z_nx_s[rd_nx_s];
    end
  end

  assign x_bus     = x_buf_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign out_idx   = out_idx_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Self-checking bench for fc_layer_seq: directed steps with random data and stalls,
// checked against a vector/result-list model of the layer sequencer.
`timescale 1ns/1ps
module tb_fc_layer_seq;
  localparam int WIDTH   = 8;
  localparam int IN      = 128;
  localparam int NEURONS = 10;
  localparam int SETTLE  = 4;
  localparam int OW      = WIDTH*2 + $clog2(IN);
  localparam int NW      = $clog2(NEURONS);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic [IN*WIDTH-1:0]   x_bus;
  logic [NEURONS*OW-1:0] z_bus;
  logic                  out_valid;
  logic                  out_ready;
  logic [OW-1:0]         out_data;
  logic [NW-1:0]         out_idx;
  logic                  out_last;
  logic                  busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] x_m [IN];
  logic [OW-1:0]    zw  [NEURONS];

  fc_layer_seq #(.WIDTH(WIDTH), .IN(IN), .NEURONS(NEURONS), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .x_bus(x_bus), .z_bus(z_bus),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_xbus(input string tag);
    for (int i = 0; i < IN; i++) chk(tag, x_bus[i*WIDTH +: WIDTH], x_m[i]);
  endtask

  // Feed one full vector; every accepted element lands in the model array.
  task automatic load_vec(input bit rnd, input bit gaps);
    int k = 0;
    int cyc = 0;
    while (k < IN && cyc < 4*IN) begin
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = rnd ? WIDTH'($urandom) : WIDTH'(k);
      chk("in_ready_load", in_ready, 1);
      if (in_valid) begin
        x_m[k] = in_data;
        k++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("load_count", k, IN);
    chk("in_ready_after_load", in_ready, 0);
    chk("busy_after_load", busy, 1);
    chk_xbus("x_bus_loaded");
  endtask

  // Present neuron results, then expect out_valid exactly SETTLE edges after the last accept.
  task automatic settle(input bit directed);
    for (int n = 0; n < NEURONS; n++) begin
      zw[n] = directed ? OW'(n*1000) : OW'($urandom);
      z_bus[n*OW +: OW] = zw[n];
    end
    in_valid = 1'b1;
    in_data  = WIDTH'($urandom);
    for (int i = 1; i <= SETTLE; i++) begin
      tick();
      chk("out_valid_settle", out_valid, (i == SETTLE));
      chk("busy_settle", busy, 1);
    end
    z_bus = '1;
  endtask

  // Drain the captured results; mode 1 uses ready pattern 1,0,0,1 then random stalls.
  task automatic drain(input int mode);
    int idx = 0;
    int cyc = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (idx < NEURONS && cyc < 400) begin
      if (mode == 0) out_ready = 1'b1;
      else if (cyc < 4) out_ready = pat[cyc];
      else out_ready = 1'($urandom_range(0, 1));
      chk("out_valid_drain", out_valid, 1);
      chk("out_data", out_data, zw[idx]);
      chk("out_idx", out_idx, idx);
      chk("out_last", out_last, (idx == NEURONS-1));
      chk("in_ready_drain", in_ready, 0);
      tick();
      if (out_ready) idx++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("drain_count", idx, NEURONS);
    chk("in_ready_after_drain", in_ready, 1);
    chk("out_valid_after_drain", out_valid, 0);
    chk("busy_after_drain", busy, 0);
    chk_xbus("x_bus_frozen");
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; z_bus = '0;
    for (int i = 0; i < IN; i++) x_m[i] = '0;

    // reset state
    tick(); tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_x_bus_zero", (x_bus === '0), 1);
    rst_n = 1'b1;
    chk("idle_in_ready", in_ready, 0);
    tick();
    chk("load_in_ready", in_ready, 1);

    // vector 1: x[k]=k, z[n]=n*1000, no stalls
    load_vec(1'b0, 1'b0);
    chk("x_el5", x_bus[5*WIDTH +: WIDTH], 8'h05);
    chk("x_el127", x_bus[127*WIDTH +: WIDTH], 8'h7F);
    settle(1'b1);
    drain(0);

    // vector 2: random data with gaps, random results, stalled drain
    load_vec(1'b1, 1'b1);
    settle(1'b0);
    drain(1);

    // flush on the 64th input handshake drops that element and restarts the count
    for (int k = 0; k < 63; k++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'($urandom);
      x_m[k]   = in_data;
      chk("in_ready_pre_flush", in_ready, 1);
      tick();
    end
    in_valid = 1'b1;
    flush    = 1'b1;
    in_data  = ~x_m[63];
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_busy", busy, 0);
    chk("flush_dropped_el63", x_bus[63*WIDTH +: WIDTH], x_m[63]);
    load_vec(1'b1, 1'b0);
    settle(1'b0);
    drain(1);

    // reset in the middle of SETTLE
    load_vec(1'b1, 1'b0);
    tick(); tick();
    chk("mid_settle_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_last", out_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_idx", out_idx, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_x_bus_zero", (x_bus === '0), 1);
    for (int i = 0; i < IN; i++) x_m[i] = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk("release_in_ready", in_ready, 0);
    tick();
    chk("release_load", in_ready, 1);
    for (int i = 0; i < SETTLE + NEURONS + 4; i++) begin
      tick();
      chk("aborted_out_valid", out_valid, 0);
      chk("aborted_in_ready", in_ready, 1);
    end

    // normal operation resumes after the abort
    load_vec(1'b1, 1'b1);
    settle(1'b0);
    drain(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
